// File: rtl/plic_gateway_arb.sv
// PLIC interrupt sequencing core: per-source gateways, claim/complete handshake, priority arbiter.
// Define PLIC_EDGE_TRIG_EN for rising-edge triggering with a one-deep deferred flag; default is level.
module plic_gateway_arb #(
  parameter int IRQ_NUM  = 32,
  parameter int IRQ_WID  = 5,
  parameter int PRIO_WID = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic [IRQ_NUM-1:0]           irq_i,
  input  logic [IRQ_NUM-1:0]           ie_i,
  input  logic [IRQ_NUM*PRIO_WID-1:0]  prio_i,
  input  logic [PRIO_WID-1:0]          thold_i,
  input  logic                         claim_i,
  input  logic                         comp_i,
  input  logic [IRQ_WID-1:0]           comp_id_i,
  output logic [IRQ_NUM-1:0]           ip_o,
  output logic [IRQ_WID-1:0]           claim_id_o,
  output logic                         ext_irq_o
);

  typedef enum logic [1:0] {
    GW_IDLE  = 2'd0,
    GW_PEND  = 2'd1,
    GW_INSVC = 2'd2
  } gw_state_e;

  gw_state_e gw_q [IRQ_NUM];
  gw_state_e gw_d [IRQ_NUM];

  logic [IRQ_WID-1:0]  best_id_q, best_id_d;
  logic [IRQ_WID-1:0]  arb_id;
  logic [PRIO_WID-1:0] arb_prio;
  logic [IRQ_NUM-1:0]  trig;
  logic                claim_hit;

`ifdef PLIC_EDGE_TRIG_EN
  logic [IRQ_NUM-1:0] irq_q, irq_d;
  logic [IRQ_NUM-1:0] deferred_q, deferred_d;

  assign irq_d = irq_i;
  assign trig  = irq_i & ~irq_q;
`else
  assign trig = irq_i;
`endif

  // A claim only acts when the bus actually read a non-zero ID.
  assign claim_hit = claim_i && (best_id_q != '0);

  always_comb begin
`ifdef PLIC_EDGE_TRIG_EN
    deferred_d = deferred_q;
`endif
    for (int n = 0; n < IRQ_NUM; n++) begin
      gw_d[n] = gw_q[n];
      case (gw_q[n])
        GW_IDLE: begin
          if (trig[n]) gw_d[n] = GW_PEND;
        end
        GW_PEND: begin
          if (claim_hit && (best_id_q == IRQ_WID'(n))) gw_d[n] = GW_INSVC;
        end
        GW_INSVC: begin
          if (comp_i && (comp_id_i == IRQ_WID'(n))) begin
`ifdef PLIC_EDGE_TRIG_EN
            if (deferred_q[n] || trig[n]) gw_d[n] = GW_PEND;
            else                          gw_d[n] = GW_IDLE;
            deferred_d[n] = 1'b0;
`else
            gw_d[n] = GW_IDLE;
`endif
          end
`ifdef PLIC_EDGE_TRIG_EN
          else if (trig[n]) begin
            deferred_d[n] = 1'b1;
          end
`endif
        end
        default: gw_d[n] = GW_IDLE;
      endcase
    end
    // Source 0 is the "no interrupt" ID and never leaves IDLE.
    gw_d[0] = GW_IDLE;
`ifdef PLIC_EDGE_TRIG_EN
    deferred_d[0] = 1'b0;
`endif
  end

  // Strict greater-than keeps the lowest ID on priority ties.
  always_comb begin
    arb_id   = '0;
    arb_prio = '0;
    for (int n = 0; n < IRQ_NUM; n++) begin
      if ((gw_q[n] == GW_PEND) && ie_i[n] &&
          (prio_i[n*PRIO_WID +: PRIO_WID] > thold_i) &&
          (prio_i[n*PRIO_WID +: PRIO_WID] > arb_prio)) begin
        arb_id   = IRQ_WID'(n);
        arb_prio = prio_i[n*PRIO_WID +: PRIO_WID];
      end
    end
  end

  // Zeroing after a claim stops the same stale ID being claimed twice.
  always_comb begin
    best_id_d = '0;
    if (!claim_hit && en_i) best_id_d = arb_id;
  end

  always_comb begin
    for (int n = 0; n < IRQ_NUM; n++) begin
      ip_o[n] = (gw_q[n] == GW_PEND);
    end
    ip_o[0] = 1'b0;
  end

  assign claim_id_o = best_id_q;
  assign ext_irq_o  = (best_id_q != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < IRQ_NUM; n++) begin
        gw_q[n] <= GW_IDLE;
      end
      best_id_q <= '0;
`ifdef PLIC_EDGE_TRIG_EN
      irq_q      <= '0;
      deferred_q <= '0;
`endif
    end else begin
      for (int n = 0; n < IRQ_NUM; n++) begin
        gw_q[n] <= gw_d[n];
      end
      best_id_q <= best_id_d;
`ifdef PLIC_EDGE_TRIG_EN
      irq_q      <= irq_d;
      deferred_q <= deferred_d;
`endif
    end
  end

endmodule

// File: tb/tb_plic_gateway_arb.sv
// Self-checking bench for plic_gateway_arb: table of arbitration vectors plus claim/complete/reset sequences.
// Expectations follow the build mode selected by PLIC_EDGE_TRIG_EN.
module tb_plic_gateway_arb;
  localparam int IRQ_NUM  = 32;
  localparam int IRQ_WID  = 5;
  localparam int PRIO_WID = 4;

  logic                        clk_i = 1'b0;
  logic                        rst_n_i;
  logic                        en_i;
  logic [IRQ_NUM-1:0]          irq_i;
  logic [IRQ_NUM-1:0]          ie_i;
  logic [IRQ_NUM*PRIO_WID-1:0] prio_i;
  logic [PRIO_WID-1:0]         thold_i;
  logic                        claim_i;
  logic                        comp_i;
  logic [IRQ_WID-1:0]          comp_id_i;
  logic [IRQ_NUM-1:0]          ip_o;
  logic [IRQ_WID-1:0]          claim_id_o;
  logic                        ext_irq_o;

  plic_gateway_arb #(
    .IRQ_NUM  (IRQ_NUM),
    .IRQ_WID  (IRQ_WID),
    .PRIO_WID (PRIO_WID)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .irq_i      (irq_i),
    .ie_i       (ie_i),
    .prio_i     (prio_i),
    .thold_i    (thold_i),
    .claim_i    (claim_i),
    .comp_i     (comp_i),
    .comp_id_i  (comp_id_i),
    .ip_o       (ip_o),
    .claim_id_o (claim_id_o),
    .ext_irq_o  (ext_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string              name;
    logic [IRQ_WID-1:0] id;
    logic               ext;
  } sb_item_t;

  sb_item_t sb_q[$];

  typedef struct {
    string               name;
    logic [31:0]         irq;
    logic [31:0]         ie;
    logic [3:0]          thold;
    logic                en;
    logic [4:0]          pa_id;
    logic [3:0]          pa_val;
    logic [4:0]          pb_id;
    logic [3:0]          pb_val;
    logic [31:0]         exp_ip;
    logic [4:0]          exp_id;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk_vec(input string name, input logic [31:0] irq, input logic [31:0] ie,
                                  input logic [3:0] thold, input logic en,
                                  input logic [4:0] pa_id, input logic [3:0] pa_val,
                                  input logic [4:0] pb_id, input logic [3:0] pb_val,
                                  input logic [31:0] exp_ip, input logic [4:0] exp_id);
    vec_t v;
    v.name = name; v.irq = irq; v.ie = ie; v.thold = thold; v.en = en;
    v.pa_id = pa_id; v.pa_val = pa_val; v.pb_id = pb_id; v.pb_val = pb_val;
    v.exp_ip = exp_ip; v.exp_id = exp_id;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [IRQ_WID-1:0] id);
    sb_item_t it;
    it.name = name;
    it.id   = id;
    it.ext  = (id != '0);
    sb_q.push_back(it);
  endtask

  task automatic sb_check();
    sb_item_t it;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, expected one queued");
    end else begin
      it = sb_q.pop_front();
      check({it.name, "_id"}, 32'(claim_id_o), 32'(it.id));
      check({it.name, "_ext"}, 32'(ext_irq_o), 32'(it.ext));
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_prio(input logic [4:0] id, input logic [3:0] val);
    prio_i[int'(id)*PRIO_WID +: PRIO_WID] = val;
  endtask

  task automatic do_reset();
    rst_n_i   = 1'b0;
    en_i      = 1'b0;
    irq_i     = '0;
    ie_i      = '0;
    prio_i    = '0;
    thold_i   = '0;
    claim_i   = 1'b0;
    comp_i    = 1'b0;
    comp_id_i = '0;
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic pulse_claim();
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
  endtask

  task automatic pulse_comp(input logic [IRQ_WID-1:0] id);
    comp_i    = 1'b1;
    comp_id_i = id;
    tick();
    comp_i    = 1'b0;
    comp_id_i = '0;
  endtask

  task automatic apply_vector(input vec_t v);
    do_reset();
    ie_i    = v.ie;
    thold_i = v.thold;
    en_i    = v.en;
    set_prio(v.pa_id, v.pa_val);
    set_prio(v.pb_id, v.pb_val);
    irq_i   = v.irq;
    tick();
    check({v.name, "_ip"}, ip_o, v.exp_ip);
    check({v.name, "_lat"}, 32'(claim_id_o), 32'd0);
    sb_push(v.name, v.exp_id);
    tick();
    sb_check();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = mk_vec("v_src3",    32'h0000_0008, 32'hFFFF_FFFF, 4'd0, 1'b1, 5'd3,  4'd2,  5'd0,  4'd0,  32'h0000_0008, 5'd3);
    vecs[1] = mk_vec("v_tie59",   32'h0000_0220, 32'hFFFF_FFFF, 4'd6, 1'b1, 5'd5,  4'd7,  5'd9,  4'd7,  32'h0000_0220, 5'd5);
    vecs[2] = mk_vec("v_thold7",  32'h0000_0220, 32'hFFFF_FFFF, 4'd7, 1'b1, 5'd5,  4'd7,  5'd9,  4'd7,  32'h0000_0220, 5'd0);
    vecs[3] = mk_vec("v_prio0",   32'h0000_0010, 32'hFFFF_FFFF, 4'd0, 1'b1, 5'd4,  4'd0,  5'd0,  4'd0,  32'h0000_0010, 5'd0);
    vecs[4] = mk_vec("v_en_off",  32'h0000_0004, 32'hFFFF_FFFF, 4'd0, 1'b0, 5'd2,  4'd5,  5'd0,  4'd0,  32'h0000_0004, 5'd0);
    vecs[5] = mk_vec("v_maxprio", 32'h0000_0006, 32'hFFFF_FFFF, 4'd0, 1'b1, 5'd1,  4'd3,  5'd2,  4'd9,  32'h0000_0006, 5'd2);
    vecs[6] = mk_vec("v_iemask",  32'h0000_1100, 32'hFFFF_FEFF, 4'd0, 1'b1, 5'd8,  4'd9,  5'd12, 4'd2,  32'h0000_1100, 5'd12);
    vecs[7] = mk_vec("v_src0",    32'h0000_0001, 32'hFFFF_FFFF, 4'd0, 1'b1, 5'd0,  4'd15, 5'd0,  4'd15, 32'h0000_0000, 5'd0);
    vecs[8] = mk_vec("v_top",     32'hC000_0000, 32'hFFFF_FFFF, 4'd0, 1'b1, 5'd30, 4'd14, 5'd31, 4'd15, 32'hC000_0000, 5'd31);
    vecs[9] = mk_vec("v_tie_th",  32'h0010_0080, 32'hFFFF_FFFF, 4'd3, 1'b1, 5'd20, 4'd4,  5'd7,  4'd4,  32'h0010_0080, 5'd7);

    rst_n_i   = 1'b0;
    en_i      = 1'b0;
    irq_i     = '0;
    ie_i      = '0;
    prio_i    = '0;
    thold_i   = '0;
    claim_i   = 1'b0;
    comp_i    = 1'b0;
    comp_id_i = '0;
    #2;
    check("reset_ip", ip_o, 32'd0);
    check("reset_id", 32'(claim_id_o), 32'd0);
    check("reset_ext", 32'(ext_irq_o), 32'd0);

    for (int i = 0; i < 10; i++) begin
      apply_vector(vecs[i]);
    end

    // Claim 5 then 9, with the forced-zero cycle between, then threshold masking.
    do_reset();
    en_i = 1'b1; ie_i = '1; thold_i = 4'd6;
    set_prio(5'd5, 4'd7); set_prio(5'd9, 4'd7);
    irq_i = 32'h0000_0220;
    tick(); tick();
    check("a_claim_read", 32'(claim_id_o), 32'd5);
    pulse_claim();
    check("a_ip_after_claim", ip_o, 32'h0000_0200);
    sb_push("a_forced_zero", 5'd0); sb_check();
    tick();
    sb_push("a_next_9", 5'd9); sb_check();
    thold_i = 4'd7;
    tick();
    sb_push("a_thold7", 5'd0); sb_check();
    pulse_claim();
    check("a_null_claim_ip", ip_o, 32'h0000_0200);
    thold_i = 4'd6;
    tick();
    sb_push("a_thold6", 5'd9); sb_check();

    // Clearing the global enable drops the candidate after one edge.
    do_reset();
    en_i = 1'b1; ie_i = '1;
    set_prio(5'd2, 4'd5);
    irq_i = 32'h0000_0004;
    tick(); tick();
    sb_push("b_src2", 5'd2); sb_check();
    en_i = 1'b0;
    tick();
    sb_push("b_en_cleared", 5'd0); sb_check();

    // Complete 6 with its line still high, then a completion of idle source 7.
    do_reset();
    en_i = 1'b1; ie_i = '1;
    set_prio(5'd6, 4'd3);
    irq_i = 32'h0000_0040;
    tick(); tick();
    sb_push("c_src6", 5'd6); sb_check();
    pulse_claim();
    check("c_ip_claimed", ip_o, 32'h0);
    tick();
    pulse_comp(5'd6);
    check("c_ip_at_comp", ip_o, 32'h0);
    tick();
`ifdef PLIC_EDGE_TRIG_EN
    check("c_ip_after_comp", ip_o, 32'h0);
`else
    check("c_ip_after_comp", ip_o, 32'h0000_0040);
`endif
    pulse_comp(5'd7);
`ifdef PLIC_EDGE_TRIG_EN
    check("c_comp7_ip", ip_o, 32'h0);
    sb_push("c_comp7", 5'd0); sb_check();
`else
    check("c_comp7_ip", ip_o, 32'h0000_0040);
    sb_push("c_comp7", 5'd6); sb_check();
`endif

    // Two pulses on source 10 while in service, then completion.
    do_reset();
    en_i = 1'b1; ie_i = '1;
    set_prio(5'd10, 4'd4);
    irq_i = 32'h0000_0400;
    tick(); tick();
    sb_push("d_src10", 5'd10); sb_check();
    pulse_claim();
    irq_i = '0;           tick();
    irq_i = 32'h0000_0400; tick();
    irq_i = '0;           tick();
    irq_i = 32'h0000_0400; tick();
    irq_i = '0;           tick();
    pulse_comp(5'd10);
`ifdef PLIC_EDGE_TRIG_EN
    check("d_ip_deferred", ip_o, 32'h0000_0400);
    tick();
    sb_push("d_reclaim_ready", 5'd10); sb_check();
    pulse_claim();
    tick();
    pulse_comp(5'd10);
    check("d_ip_second_comp", ip_o, 32'h0);
    tick();
    check("d_ip_stays_clear", ip_o, 32'h0);
    sb_push("d_idle", 5'd0); sb_check();
`else
    check("d_ip_level", ip_o, 32'h0);
    tick();
    sb_push("d_idle", 5'd0); sb_check();
`endif

    // Reset while 1 and 2 are in service and 3 is pending.
    do_reset();
    en_i = 1'b1; ie_i = '1;
    set_prio(5'd1, 4'd5); set_prio(5'd2, 4'd4); set_prio(5'd3, 4'd3);
    irq_i = 32'h0000_000E;
    tick(); tick();
    sb_push("e_src1", 5'd1); sb_check();
    pulse_claim();
    tick();
    sb_push("e_src2", 5'd2); sb_check();
    pulse_claim();
    tick();
    sb_push("e_src3", 5'd3); sb_check();
    check("e_ip_before_reset", ip_o, 32'h0000_0008);
    rst_n_i = 1'b0;
    #2;
    check("e_rst_ip", ip_o, 32'h0);
    check("e_rst_id", 32'(claim_id_o), 32'd0);
    check("e_rst_ext", 32'(ext_irq_o), 32'd0);
    irq_i = '0;
    tick();
    rst_n_i = 1'b1;
    tick();
    pulse_comp(5'd1);
    tick();
    check("e_comp_after_reset_ip", ip_o, 32'h0);
    sb_push("e_comp_after_reset", 5'd0); sb_check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
